// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V main controller:
// state codes, opcodes and datapath select values.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been waiting; expired is high once
// the count has reached MAX_WAIT. clear has priority over count.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (count && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM: sequences fetch, decode, execute, memory
// and write-back one step per cycle, with bounded memory waits and traps.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int EN_ITYPE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic       illegal,
  output logic       timeout,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   is_load_q, is_load_d;
  logic   illegal_q, illegal_d;
  logic   timeout_q, timeout_d;
  logic   timer_clear, timer_count, timer_expired;

  // Memory handshake: mem_read/mem_write and iord are held constant in a
  // wait state until mem_ready is sampled high on a rising edge; that edge
  // completes the access. A wait state whose counter has already reached
  // MAX_WAIT traps unless mem_ready is high in that same cycle.
  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .count   (timer_count),
    .expired (timer_expired)
  );

  assign timer_clear = (state_d != state_q);
  assign timer_count = is_wait_state(state_q) && !mem_ready;

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timer_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_DECODE: begin
        is_load_d = (opcode == OPC_LOAD);
        case (opcode)
          OPC_OP:              state_d = S_EXEC_R;
          OPC_LOAD, OPC_STORE: state_d = S_MEM_ADDR;
          OPC_BRANCH:          state_d = S_BRANCH;
          OPC_JAL:             state_d = S_JAL;
          OPC_OP_IMM: begin
            if (EN_ITYPE != 0) begin
              state_d = S_EXEC_I;
            end else begin
              state_d   = S_TRAP;
              illegal_d = 1'b1;
            end
          end
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR:         state_d = is_load_q ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (timer_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timer_expired) begin
          state_d   = S_TRAP;
          timeout_d = 1'b1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      is_load_q <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    reg_write  = 1'b0;
    mem_to_reg = M2R_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch/JAL target from the instruction's own PC.
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_R;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_I;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_WB_ALU: reg_write = 1'b1;
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_MDR;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_SUB;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_PC;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
      end
      default: ;
    endcase
    // Nothing is strobed while reset is held, so an in-flight access is dropped.
    if (rst) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      alu_op     = ALU_ADD;
      reg_write  = 1'b0;
      mem_to_reg = M2R_ALUOUT;
    end
  end

  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table for the main
// instruction flows plus hand sequences for traps, timeouts and reset abort.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       zero;

  logic       a_mem_read, a_mem_write, a_iord, a_ir_write, a_pc_write, a_pc_src;
  logic [1:0] a_alu_src_a, a_alu_src_b, a_alu_op, a_mem_to_reg;
  logic       a_reg_write, a_illegal, a_timeout;
  logic [3:0] a_state;

  logic       b_mem_read, b_mem_write, b_iord, b_ir_write, b_pc_write, b_pc_src;
  logic [1:0] b_alu_src_a, b_alu_src_b, b_alu_op, b_mem_to_reg;
  logic       b_reg_write, b_illegal, b_timeout;
  logic [3:0] b_state;

  logic [16:0] a_word, b_word;
  assign a_word = {a_mem_read, a_mem_write, a_iord, a_ir_write, a_pc_write, a_pc_src,
                   a_alu_src_a, a_alu_src_b, a_alu_op, a_reg_write, a_mem_to_reg,
                   a_illegal, a_timeout};
  assign b_word = {b_mem_read, b_mem_write, b_iord, b_ir_write, b_pc_write, b_pc_src,
                   b_alu_src_a, b_alu_src_b, b_alu_op, b_reg_write, b_mem_to_reg,
                   b_illegal, b_timeout};

  multicycle_ctrl #(.MAX_WAIT(15), .EN_ITYPE(1)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .iord(a_iord),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_src(a_pc_src),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
    .reg_write(a_reg_write), .mem_to_reg(a_mem_to_reg),
    .illegal(a_illegal), .timeout(a_timeout), .state(a_state)
  );

  multicycle_ctrl #(.MAX_WAIT(4), .EN_ITYPE(0)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .iord(b_iord),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
    .reg_write(b_reg_write), .mem_to_reg(b_mem_to_reg),
    .illegal(b_illegal), .timeout(b_timeout), .state(b_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  opc;
    logic        rdy;
    logic        z;
    logic [3:0]  st;
    logic [16:0] ow;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  logic [16:0] W_ZERO, W_FETCH_NR, W_FETCH, W_DECODE, W_EXEC_R, W_EXEC_I, W_MADDR;
  logic [16:0] W_MRD, W_MWR, W_WBALU, W_WBMEM, W_BR1, W_BR0, W_JAL, W_TRAP_ILL, W_TRAP_TO;

  // Output word order: mem_read mem_write iord ir_write pc_write pc_src
  // alu_src_a alu_src_b alu_op reg_write mem_to_reg illegal timeout.
  function automatic logic [16:0] ow(input logic mr, mw, io, irw, pcw, pcs,
                                     input logic [1:0] a, b, op,
                                     input logic rw, input logic [1:0] m2r,
                                     input logic ill, to);
    return {mr, mw, io, irw, pcw, pcs, a, b, op, rw, m2r, ill, to};
  endfunction

  function automatic vec_t mk(input logic [6:0] opc, input logic rdy, z,
                              input logic [3:0] st, input logic [16:0] w);
    vec_t v;
    v.opc = opc; v.rdy = rdy; v.z = z; v.st = st; v.ow = w;
    return v;
  endfunction

  // Scoreboard helpers
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs checked 1ns later.
  task automatic cyc(input logic [6:0] opc, input logic rdy, input logic z);
    @(negedge clk);
    rst       = 1'b0;
    opcode    = opc;
    mem_ready = rdy;
    zero      = z;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    opcode    = 7'd0;
    mem_ready = 1'b1;
    zero      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 7'd0; mem_ready = 1'b0; zero = 1'b0;

    W_ZERO     = 17'd0;
    W_FETCH_NR = ow(1,0,0,0,0,0,2'b00,2'b01,2'b00,0,2'b00,0,0);
    W_FETCH    = ow(1,0,0,1,1,0,2'b00,2'b01,2'b00,0,2'b00,0,0);
    W_DECODE   = ow(0,0,0,0,0,0,2'b01,2'b10,2'b00,0,2'b00,0,0);
    W_EXEC_R   = ow(0,0,0,0,0,0,2'b10,2'b00,2'b10,0,2'b00,0,0);
    W_EXEC_I   = ow(0,0,0,0,0,0,2'b10,2'b10,2'b11,0,2'b00,0,0);
    W_MADDR    = ow(0,0,0,0,0,0,2'b10,2'b10,2'b00,0,2'b00,0,0);
    W_MRD      = ow(1,0,1,0,0,0,2'b00,2'b00,2'b00,0,2'b00,0,0);
    W_MWR      = ow(0,1,1,0,0,0,2'b00,2'b00,2'b00,0,2'b00,0,0);
    W_WBALU    = ow(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,0,0);
    W_WBMEM    = ow(0,0,0,0,0,0,2'b00,2'b00,2'b00,1,2'b01,0,0);
    W_BR1      = ow(0,0,0,0,1,1,2'b10,2'b00,2'b01,0,2'b00,0,0);
    W_BR0      = ow(0,0,0,0,0,1,2'b10,2'b00,2'b01,0,2'b00,0,0);
    W_JAL      = ow(0,0,0,0,1,1,2'b00,2'b00,2'b00,1,2'b10,0,0);
    W_TRAP_ILL = ow(0,0,0,0,0,0,2'b00,2'b00,2'b00,0,2'b00,1,0);
    W_TRAP_TO  = ow(0,0,0,0,0,0,2'b00,2'b00,2'b00,0,2'b00,0,1);

    // R-type, zero wait: 4 cycles
    tbl.push_back(mk(OP_R, 1, 0, 4'd0, W_FETCH));
    tbl.push_back(mk(OP_R, 1, 0, 4'd1, W_DECODE));
    tbl.push_back(mk(OP_R, 1, 0, 4'd2, W_EXEC_R));
    tbl.push_back(mk(OP_R, 1, 0, 4'd7, W_WBALU));
    // I-type (legal on instance A)
    tbl.push_back(mk(OP_I, 1, 0, 4'd0, W_FETCH));
    tbl.push_back(mk(OP_I, 1, 0, 4'd1, W_DECODE));
    tbl.push_back(mk(OP_I, 1, 0, 4'd3, W_EXEC_I));
    tbl.push_back(mk(OP_I, 1, 0, 4'd7, W_WBALU));
    // Load with 3 wait cycles in MEM_RD: 8 cycles
    tbl.push_back(mk(OP_LD, 1, 0, 4'd0, W_FETCH));
    tbl.push_back(mk(OP_LD, 1, 0, 4'd1, W_DECODE));
    tbl.push_back(mk(OP_LD, 1, 0, 4'd4, W_MADDR));
    tbl.push_back(mk(OP_LD, 0, 0, 4'd5, W_MRD));
    tbl.push_back(mk(OP_LD, 0, 0, 4'd5, W_MRD));
    tbl.push_back(mk(OP_LD, 0, 0, 4'd5, W_MRD));
    tbl.push_back(mk(OP_LD, 1, 0, 4'd5, W_MRD));
    tbl.push_back(mk(OP_LD, 1, 0, 4'd8, W_WBMEM));
    // Store with one wait in FETCH and one in MEM_WR
    tbl.push_back(mk(OP_ST, 0, 0, 4'd0, W_FETCH_NR));
    tbl.push_back(mk(OP_ST, 1, 0, 4'd0, W_FETCH));
    tbl.push_back(mk(OP_ST, 1, 0, 4'd1, W_DECODE));
    tbl.push_back(mk(OP_ST, 1, 0, 4'd4, W_MADDR));
    tbl.push_back(mk(OP_ST, 0, 0, 4'd6, W_MWR));
    tbl.push_back(mk(OP_ST, 1, 0, 4'd6, W_MWR));
    // Branch taken, then not taken
    tbl.push_back(mk(OP_BR, 1, 1, 4'd0, W_FETCH));
    tbl.push_back(mk(OP_BR, 1, 1, 4'd1, W_DECODE));
    tbl.push_back(mk(OP_BR, 1, 1, 4'd9, W_BR1));
    tbl.push_back(mk(OP_BR, 1, 0, 4'd0, W_FETCH));
    tbl.push_back(mk(OP_BR, 1, 0, 4'd1, W_DECODE));
    tbl.push_back(mk(OP_BR, 1, 0, 4'd9, W_BR0));
    // JAL, then back in FETCH
    tbl.push_back(mk(OP_JAL, 1, 0, 4'd0, W_FETCH));
    tbl.push_back(mk(OP_JAL, 1, 0, 4'd1, W_DECODE));
    tbl.push_back(mk(OP_JAL, 1, 0, 4'd10, W_JAL));
    tbl.push_back(mk(OP_R, 1, 0, 4'd0, W_FETCH));

    // Reset state on both instances
    do_reset();
    chk("reset_a_state", 32'(a_state), 32'd0);
    chk("reset_a_outs", 32'(a_word), 32'(W_ZERO));
    chk("reset_b_state", 32'(b_state), 32'd0);
    chk("reset_b_outs", 32'(b_word), 32'(W_ZERO));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].opc, tbl[i].rdy, tbl[i].z);
      chk($sformatf("vec%0d_state", i), 32'(a_state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_outs", i), 32'(a_word), 32'(tbl[i].ow));
    end

    // I-type with EN_ITYPE=0 traps on B; trap is absorbing until reset
    do_reset();
    cyc(OP_I, 1, 0);
    cyc(OP_I, 1, 0);
    chk("itype_b_decode", 32'(b_state), 32'd1);
    cyc(OP_I, 1, 0);
    chk("itype_a_exec_i", 32'(a_state), 32'd3);
    chk("itype_b_trap", 32'(b_state), 32'd11);
    chk("itype_b_outs", 32'(b_word), 32'(W_TRAP_ILL));
    for (int i = 0; i < 20; i++) begin
      cyc(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk($sformatf("trap_hold%0d_state", i), 32'(b_state), 32'd11);
      chk($sformatf("trap_hold%0d_outs", i), 32'(b_word), 32'(W_TRAP_ILL));
    end
    do_reset();
    chk("trap_cleared_b_state", 32'(b_state), 32'd0);
    chk("trap_cleared_b_outs", 32'(b_word), 32'(W_ZERO));

    // Unknown opcode traps on A
    cyc(OP_BAD, 1, 0);
    cyc(OP_BAD, 1, 0);
    cyc(OP_BAD, 1, 0);
    chk("bad_opc_a_state", 32'(a_state), 32'd11);
    chk("bad_opc_a_outs", 32'(a_word), 32'(W_TRAP_ILL));

    // Timeout on B (MAX_WAIT=4): 4 counted waits, then expiry cycle traps
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      cyc(OP_R, 0, 0);
      chk($sformatf("to_wait%0d_b_outs", c), 32'(b_word), 32'(W_FETCH_NR));
    end
    cyc(OP_R, 0, 0);
    chk("to_b_state", 32'(b_state), 32'd11);
    chk("to_b_outs", 32'(b_word), 32'(W_TRAP_TO));
    chk("to_a_still_waiting", 32'(a_word), 32'(W_FETCH_NR));

    // mem_ready arriving while the counter equals MAX_WAIT wins
    do_reset();
    for (int c = 1; c <= 4; c++) cyc(OP_R, 0, 0);
    cyc(OP_R, 1, 0);
    chk("late_rdy_b_fetch", 32'(b_word), 32'(W_FETCH));
    cyc(OP_R, 1, 0);
    chk("late_rdy_b_state", 32'(b_state), 32'd1);
    chk("late_rdy_b_outs", 32'(b_word), 32'(W_DECODE));

    // Reset during a stalled store drops the write
    do_reset();
    cyc(OP_ST, 1, 0);
    cyc(OP_ST, 1, 0);
    cyc(OP_ST, 1, 0);
    cyc(OP_ST, 0, 0);
    chk("abort_a_mwr", 32'(a_word), 32'(W_MWR));
    @(negedge clk);
    rst       = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("abort_rst_mem_write", 32'(a_mem_write), 32'd0);
    cyc(OP_ST, 0, 0);
    chk("abort_a_state", 32'(a_state), 32'd0);
    chk("abort_a_outs", 32'(a_word), 32'(W_FETCH_NR));
    chk("abort_b_state", 32'(b_state), 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
